// File: rtl/flow_led_pkg.sv
// Shared constants for the flow-LED pattern engine: pattern mode codes and
// ping-pong direction.
package flow_led_pkg;

  localparam logic [1:0] MODE_ROL   = 2'd0;
  localparam logic [1:0] MODE_ROR   = 2'd1;
  localparam logic [1:0] MODE_PING  = 2'd2;
  localparam logic [1:0] MODE_BLINK = 2'd3;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_e;

endpackage

// File: rtl/flow_led_tick.sv
// Prescaler for the flow-LED engine: emits a combinational tick once every
// (CNT_MAX >> speed) + 1 enabled cycles.
module flow_led_tick #(
  parameter int unsigned     CNT_W   = 25,
  parameter logic [CNT_W-1:0] CNT_MAX = 25'd24_999_999
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       clr,
  input  logic       en,
  input  logic [1:0] speed,
  output logic       tick
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] limit;

  // >= rather than == so that lowering the limit mid-period ticks at once.
  always_comb begin
    limit = CNT_MAX >> speed;
    tick  = en && (cnt >= limit);
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst || clr) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/flow_led_gen.sv
// Flow-LED pattern engine: drives LED_NUM LEDs with rotate-left/right,
// ping-pong or blink-all patterns advanced by a prescaled tick.
module flow_led_gen
  import flow_led_pkg::*;
#(
  parameter int unsigned      LED_NUM = 8,
  parameter int unsigned      CNT_W   = 25,
  parameter logic [CNT_W-1:0] CNT_MAX = 25'd24_999_999
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  input  logic [1:0]         mode,
  input  logic [1:0]         speed,
  input  logic               pause,
  output logic [LED_NUM-1:0] led,
  output logic               step
);

  if (LED_NUM < 2) begin : g_led_num_check
    $error("flow_led_gen: LED_NUM must be at least 2");
  end

  localparam logic [LED_NUM-1:0] LED_LSB = LED_NUM'(1);
  localparam logic [LED_NUM-1:0] LED_MSB = LED_LSB << (LED_NUM - 1);

  logic [1:0]         mode_q;
  dir_e               dir;
  dir_e               dir_next;
  logic [LED_NUM-1:0] led_next;
  logic               step_next;
  logic               mode_chg;
  logic               tick;

  assign mode_chg = (mode != mode_q);

  flow_led_tick #(
    .CNT_W   (CNT_W),
    .CNT_MAX (CNT_MAX)
  ) u_tick (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .clr     (mode_chg),
    .en      (!pause),
    .speed   (speed),
    .tick    (tick)
  );

  // Mode change wins over tick; pause is folded into tick via the prescaler enable.
  always_comb begin
    led_next  = led;
    dir_next  = dir;
    step_next = 1'b0;
    if (mode_chg) begin
      dir_next = DIR_LEFT;
      case (mode)
        MODE_ROR:   led_next = LED_MSB;
        MODE_BLINK: led_next = '1;
        default:    led_next = LED_LSB;
      endcase
    end else if (tick) begin
      step_next = 1'b1;
      case (mode_q)
        MODE_ROL: led_next = {led[LED_NUM-2:0], led[LED_NUM-1]};
        MODE_ROR: led_next = {led[0], led[LED_NUM-1:1]};
        MODE_PING: begin
          // Reverse at the ends so each end LED is lit once per bounce.
          if (dir == DIR_LEFT) begin
            if (led[LED_NUM-1]) begin
              dir_next = DIR_RIGHT;
              led_next = led >> 1;
            end else begin
              led_next = led << 1;
            end
          end else begin
            if (led[0]) begin
              dir_next = DIR_LEFT;
              led_next = led << 1;
            end else begin
              led_next = led >> 1;
            end
          end
        end
        default: led_next = ~led;
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      led    <= LED_LSB;
      step   <= 1'b0;
      dir    <= DIR_LEFT;
      mode_q <= MODE_ROL;
    end else begin
      led    <= led_next;
      step   <= step_next;
      dir    <= dir_next;
      mode_q <= mode;
    end
  end

endmodule

// File: tb/tb_flow_led_gen.sv
// Scoreboard bench for flow_led_gen with LED_NUM=4, CNT_MAX=4: expected LED
// events are queued with their cycle and checked by an independent monitor.
module tb_flow_led_gen;

  typedef struct {
    logic [3:0]  led;
    logic        step;
    int unsigned cyc;
  } exp_t;

  logic       sys_clk;
  logic       sys_rst;
  logic [1:0] mode;
  logic [1:0] speed;
  logic       pause;
  logic [3:0] led;
  logic       step;

  exp_t        exp_q[$];
  int unsigned cyc = 0;
  int          total = 0;
  int          bad = 0;
  int unsigned t;
  logic [3:0]  prev_led = 'x;

  flow_led_gen #(
    .LED_NUM (4),
    .CNT_W   (3),
    .CNT_MAX (3'd4)
  ) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .mode    (mode),
    .speed   (speed),
    .pause   (pause),
    .led     (led),
    .step    (step)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic push(input logic [3:0] l, input logic s, input int unsigned c);
    exp_t e;
    e.led  = l;
    e.step = s;
    e.cyc  = c;
    exp_q.push_back(e);
  endtask

  task automatic wait_cyc(input int unsigned n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  // An event is any LED change or a step strobe; each must match the queue head.
  always @(negedge sys_clk) begin
    exp_t e;
    if (led !== prev_led || step === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_event cyc=%0d got led=%b step=%b, want no event",
                 cyc, led, step);
      end else begin
        e = exp_q.pop_front();
        if (led !== e.led || step !== e.step || cyc != e.cyc)
          begin
          bad++;
          $display("FAIL led_event got led=%b step=%b cyc=%0d, want led=%b step=%b cyc=%0d",
                   led, step, cyc, e.led, e.step, e.cyc);
        end
      end
    end
    prev_led = led;
  end

  logic [3:0] ping_seq [7];

  initial begin
    ping_seq = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};
    sys_rst = 1'b1;
    mode    = 2'd0;
    speed   = 2'd0;
    pause   = 1'b0;

    // Reset state, then rotate left.
    push(4'b0001, 1'b0, 1);
    wait_cyc(2);
    sys_rst = 1'b0;
    t = cyc;
    push(4'b0010, 1'b1, t + 5);
    push(4'b0100, 1'b1, t + 10);
    push(4'b1000, 1'b1, t + 15);
    push(4'b0001, 1'b1, t + 20);
    wait_cyc(20);

    // Mode switch to rotate-right with cnt=3.
    wait_cyc(3);
    mode = 2'd1;
    t = cyc;
    push(4'b1000, 1'b0, t + 1);
    push(4'b0100, 1'b1, t + 6);
    push(4'b0010, 1'b1, t + 11);
    wait_cyc(11);

    // Ping-pong.
    mode = 2'd2;
    t = cyc;
    push(4'b0001, 1'b0, t + 1);
    for (int i = 0; i < 7; i++) push(ping_seq[i], 1'b1, t + 6 + 5 * i);
    wait_cyc(36);

    // Pause 12 cycles at cnt=2 in rotate-left.
    mode = 2'd0;
    t = cyc;
    push(4'b0001, 1'b0, t + 1);
    push(4'b0010, 1'b1, t + 18);
    wait_cyc(3);
    pause = 1'b1;
    wait_cyc(12);
    pause = 1'b0;
    wait_cyc(3);

    // Speed 1 (period 3), then speed 3 (every cycle).
    speed = 2'd1;
    t = cyc;
    push(4'b0100, 1'b1, t + 3);
    push(4'b1000, 1'b1, t + 6);
    push(4'b0001, 1'b1, t + 9);
    wait_cyc(9);
    speed = 2'd3;
    t = cyc;
    push(4'b0010, 1'b1, t + 1);
    push(4'b0100, 1'b1, t + 2);
    push(4'b1000, 1'b1, t + 3);
    push(4'b0001, 1'b1, t + 4);
    wait_cyc(4);

    // Speed 0 -> 1 at cnt=3 ticks on the next cycle.
    speed = 2'd0;
    wait_cyc(3);
    speed = 2'd1;
    t = cyc;
    push(4'b0010, 1'b1, t + 1);
    wait_cyc(1);
    speed = 2'd0;

    // Blink, then reset mid-period.
    mode = 2'd3;
    t = cyc;
    push(4'b1111, 1'b0, t + 1);
    push(4'b0000, 1'b1, t + 6);
    push(4'b1111, 1'b1, t + 11);
    wait_cyc(13);
    sys_rst = 1'b1;
    mode    = 2'd0;
    t = cyc;
    push(4'b0001, 1'b0, t + 1);
    wait_cyc(1);
    sys_rst = 1'b0;
    push(4'b0010, 1'b1, t + 6);
    wait_cyc(5);

    // Non-zero mode at reset release reloads on the first cycle.
    sys_rst = 1'b1;
    mode    = 2'd1;
    t = cyc;
    push(4'b0001, 1'b0, t + 1);
    wait_cyc(1);
    sys_rst = 1'b0;
    push(4'b1000, 1'b0, t + 2);
    push(4'b0100, 1'b1, t + 7);
    wait_cyc(6);

    wait_cyc(3);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL leftover_events got %0d pending, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
